// File: rtl/alu_op_pkg.sv
// Shared constants and FSM state type for the ALU op sequencer and its decoder.
package alu_op_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_VALID
    } state_e;

    localparam int CNT_W       = 4;

    localparam int OPC_RTYPE   = 0;
    localparam int OPC_IMM_LO  = 1;
    localparam int OPC_IMM_HI  = 4;

    localparam int FUNC_FIRST  = 1;
    localparam int FUNC_RUN_LO = 3;
    localparam int FUNC_RUN_HI = 10;
    localparam int FUNC_MUL    = 11;
    localparam int FUNC_DIV    = 12;

    localparam int SEL_FIRST   = 0;
    localparam int SEL_RUN_LO  = 1;
    localparam int SEL_IMM_LO  = 9;
    localparam int SEL_MUL     = 13;
    localparam int SEL_DIV     = 14;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/function decode into an ALU select plus multi-cycle,
// divide and undefined-code flags. Undefined codes give an all-ones select.
module alu_op_decode
    import alu_op_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int FUNC_W = 6,
    parameter int SEL_W  = 4
) (
    input  logic [OP_W-1:0]   opCode,
    input  logic [FUNC_W-1:0] func,
    output logic [SEL_W-1:0]  sel,
    output logic              multi,
    output logic              is_div,
    output logic              undef
);

    always_comb begin
        sel    = '1;
        multi  = 1'b0;
        is_div = 1'b0;
        undef  = 1'b1;
        if (opCode == OP_W'(OPC_RTYPE)) begin
            if (func == FUNC_W'(FUNC_FIRST)) begin
                sel   = SEL_W'(SEL_FIRST);
                undef = 1'b0;
            end else if (func >= FUNC_W'(FUNC_RUN_LO) && func <= FUNC_W'(FUNC_RUN_HI)) begin
                // func 3..10 is a contiguous run landing on selects 1..8
                sel   = SEL_W'(func - FUNC_W'(FUNC_RUN_LO - SEL_RUN_LO));
                undef = 1'b0;
            end else if (func == FUNC_W'(FUNC_MUL)) begin
                sel   = SEL_W'(SEL_MUL);
                multi = 1'b1;
                undef = 1'b0;
            end else if (func == FUNC_W'(FUNC_DIV)) begin
                sel    = SEL_W'(SEL_DIV);
                multi  = 1'b1;
                is_div = 1'b1;
                undef  = 1'b0;
            end
        end else if (opCode >= OP_W'(OPC_IMM_LO) && opCode <= OP_W'(OPC_IMM_HI)) begin
            sel   = SEL_W'(opCode) + SEL_W'(SEL_IMM_LO - OPC_IMM_LO);
            undef = 1'b0;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU-select sequencer with multi-cycle mul/div hold-off.
// Define ALU_OP_ILLEGAL_TRAP_EN to flag undefined codes and count them in err_cnt.
module alu_op_sequencer
    import alu_op_pkg::*;
#(
    parameter int OP_W       = 6,
    parameter int FUNC_W     = 6,
    parameter int SEL_W      = 4,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   opCode,
    input  logic [FUNC_W-1:0] func,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  alu_sel,
    output logic              busy,
    output logic              illegal,
    output logic [7:0]        err_cnt
);

`ifdef ALU_OP_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               illegal_q, illegal_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic [SEL_W-1:0]   dec_sel;
    logic               dec_multi, dec_div, dec_undef;
    logic               ready_w, accept;

    alu_op_decode #(
        .OP_W   (OP_W),
        .FUNC_W (FUNC_W),
        .SEL_W  (SEL_W)
    ) u_decode (
        .opCode (opCode),
        .func   (func),
        .sel    (dec_sel),
        .multi  (dec_multi),
        .is_div (dec_div),
        .undef  (dec_undef)
    );

    assign ready_w  = (state_q == ST_IDLE) || ((state_q == ST_VALID) && out_ready);
    assign accept   = in_valid && ready_w;
    assign in_ready = ready_w && !rst;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        illegal_d   = illegal_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    state_d     = ST_VALID;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_IDLE, ST_VALID: begin
                if (accept) begin
                    sel_d     = dec_sel;
                    illegal_d = TRAP_EN && dec_undef;
                    if (TRAP_EN && dec_undef && err_cnt_q != 8'hFF)
                        err_cnt_d = err_cnt_q + 8'd1;
                    if (dec_multi) begin
                        // counter expires on the edge that makes the result visible
                        state_d     = ST_EXEC;
                        busy_d      = 1'b1;
                        out_valid_d = 1'b0;
                        cnt_d       = dec_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
                    end else begin
                        state_d     = ST_VALID;
                        out_valid_d = 1'b1;
                    end
                end else if (state_q == ST_IDLE || out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            illegal_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            illegal_q   <= illegal_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_sel   = sel_q;
    assign busy      = busy_q;
    assign illegal   = illegal_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_alu_op_sequencer;

`ifdef ALU_OP_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] opCode = '0;
    logic [5:0] func = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] alu_sel;
    logic       busy;
    logic       illegal;
    logic [7:0] err_cnt;

    int n_chk = 0;
    int n_err = 0;

    alu_op_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opCode    (opCode),
        .func      (func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_sel   (alu_sel),
        .busy      (busy),
        .illegal   (illegal),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode table for opCode 0, indexed by func; -1 = undefined.
    int rtab [0:15] = '{-1, 0, -1, 1, 2, 3, 4, 5, 6, 7, 8, 13, 14, -1, -1, -1};

    function automatic int ref_code(input int op, input int fn);
        if (op == 0) return (fn < 16) ? rtab[fn] : -1;
        if (op >= 1 && op <= 4) return 8 + op;
        return -1;
    endfunction

    function automatic int ref_lat(input int code);
        if (code == 13) return MUL_LAT;
        if (code == 14) return DIV_LAT;
        return 1;
    endfunction

    // Model: a result is either presented (m_valid) or pending for m_wait more edges.
    logic       m_valid = 1'b0;
    int         m_wait  = 0;
    int         m_sel   = 0;
    logic       m_ill   = 1'b0;
    int         m_err   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_wait  <= 0;
            m_sel   <= 0;
            m_ill   <= 1'b0;
            m_err   <= 0;
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_valid <= 1'b1;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_sel <= (ref_code(int'(opCode), int'(func)) < 0) ? 15 : ref_code(int'(opCode), int'(func));
            m_ill <= TRAP && (ref_code(int'(opCode), int'(func)) < 0);
            if (TRAP && ref_code(int'(opCode), int'(func)) < 0 && m_err < 255) m_err <= m_err + 1;
            if (ref_lat(ref_code(int'(opCode), int'(func))) == 1) begin
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
                m_wait  <= ref_lat(ref_code(int'(opCode), int'(func)));
            end
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        #3;
        if (rst) begin
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_alu_sel", 32'(alu_sel), 0);
            chk("rst_illegal", 32'(illegal), 0);
            chk("rst_err_cnt", 32'(err_cnt), 0);
            chk("rst_in_ready", 32'(in_ready), 0);
        end else begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("busy", 32'(busy), 32'(m_wait != 0));
            chk("in_ready", 32'(in_ready), 32'((m_wait == 0) && (!m_valid || out_ready)));
            chk("err_cnt", 32'(err_cnt), 32'(m_err));
            if (m_valid) begin
                chk("alu_sel", 32'(alu_sel), 32'(m_sel));
                chk("illegal", 32'(illegal), 32'(m_ill));
            end
        end
    end

    int nbusy;
    int nvalid;
    bit seen;
    int r;

    initial begin
        // Reset release; ready in the first cycle after.
        @(negedge clk); #1; rst = 1'b0;
        #2; chk("rel_in_ready", 32'(in_ready), 1);

        // Single-cycle op: func 4 -> select 2, visible for exactly one cycle.
        @(negedge clk); #1; in_valid = 1'b1; opCode = 6'd0; func = 6'd4; out_ready = 1'b1;
        @(negedge clk); #1; in_valid = 1'b0;
        #2; chk("A_valid", 32'(out_valid), 1); chk("A_sel", 32'(alu_sel), 2);
        @(negedge clk); #3; chk("A_once", 32'(out_valid), 0);
        $display("txn A: opCode=0 func=4 -> sel=%0d", alu_sel);

        // Divide: 8 busy cycles, no accept while busy, then select 14.
        @(negedge clk); #1; in_valid = 1'b1; opCode = 6'd0; func = 6'd12;
        nbusy = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #3;
            if (out_valid) seen = 1'b1;
            else begin
                if (busy) nbusy++;
                chk("B_no_accept", 32'(in_ready), 0);
            end
        end
        in_valid = 1'b0;
        chk("B_busy_cycles", 32'(nbusy), 8);
        chk("B_valid", 32'(out_valid), 1);
        chk("B_sel", 32'(alu_sel), 14);
        $display("txn B: div busy=%0d sel=%0d", nbusy, alu_sel);
        @(negedge clk);

        // Back-pressure: opCode 3 held 5 cycles, then queued opCode 1 accepted back-to-back.
        @(negedge clk); #1; in_valid = 1'b1; opCode = 6'd3; func = 6'd0; out_ready = 1'b0;
        @(negedge clk); #1; opCode = 6'd1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            #2;
            chk("C_hold_valid", 32'(out_valid), 1);
            chk("C_hold_sel", 32'(alu_sel), 11);
        end
        @(negedge clk); #1; out_ready = 1'b1;
        #2; chk("C_in_ready", 32'(in_ready), 1);
        @(negedge clk); #1; in_valid = 1'b0;
        #2; chk("C2_valid", 32'(out_valid), 1); chk("C2_sel", 32'(alu_sel), 9);
        $display("txn C: opCode=3 held, then opCode=1 -> sel=%0d", alu_sel);

        // Reset two cycles into a multiply discards it.
        @(negedge clk); #1; in_valid = 1'b1; opCode = 6'd0; func = 6'd11; out_ready = 1'b1;
        @(negedge clk); #1; in_valid = 1'b0;
        @(negedge clk); #1; rst = 1'b1;
        #2;
        chk("D_valid", 32'(out_valid), 0);
        chk("D_busy", 32'(busy), 0);
        chk("D_sel", 32'(alu_sel), 0);
        @(negedge clk); #1; rst = 1'b0;
        #2; chk("D_rel_ready", 32'(in_ready), 1);
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #3;
            if (out_valid) nvalid++;
        end
        chk("D_no_result", 32'(nvalid), 0);
        $display("txn D: mul aborted by reset, results after=%0d", nvalid);

        // 300 undefined requests back-to-back.
        @(negedge clk); #1; in_valid = 1'b1; opCode = 6'd7; func = 6'd0; out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (i == 299) in_valid = 1'b0;
            #2;
            chk("E_valid", 32'(out_valid), 1);
            chk("E_sel", 32'(alu_sel), 15);
            chk("E_illegal", 32'(illegal), 32'(TRAP));
        end
        chk("E_err_cnt", 32'(err_cnt), TRAP ? 255 : 0);
        $display("txn E: 300 x opCode=7 err_cnt=%0d illegal=%0d", err_cnt, illegal);

        // Randomized traffic with occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            rst      = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            r        = int'($urandom_range(0, 3));
            if (r < 2)       opCode = 6'd0;
            else if (r == 2) opCode = 6'($urandom_range(1, 4));
            else             opCode = 6'($urandom_range(0, 63));
            func      = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk); #1; rst = 1'b0; in_valid = 1'b0;
        @(negedge clk); #4;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter OP_W, default 6, opcode field width.
REQ-002 Parameter FUNC_W, default 6, function field width.
REQ-003 Parameter SEL_W, default 4, ALU select width; SEL_W SHALL be at least 4.
REQ-004 Parameter MUL_CYCLES, default 3, multiply latency in cycles; legal range 2..15.
REQ-005 Parameter DIV_CYCLES, default 8, divide latency in cycles; legal range 2..15.
REQ-006 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1, asynchronous active-high reset.
REQ-008 Port in_valid, input, 1, request present.
REQ-009 Port in_ready, output, 1, request accepted when in_valid && in_ready.
REQ-010 Port opCode, input, OP_W, instruction opcode.
REQ-011 Port func, input, FUNC_W, R-type function code.
REQ-012 Port out_valid, output, 1, alu_sel valid.
REQ-013 Port out_ready, input, 1, consumer takes result when out_valid && out_ready.
REQ-014 Port alu_sel, output, SEL_W, registered ALU select.
REQ-015 Port busy, output, 1, multi-cycle op in progress.
REQ-016 Port illegal, output, 1, current result is an undefined code (macro-dependent).
REQ-017 Port err_cnt, output, 8, saturating illegal-request count (macro-dependent).

Function
REQ-018 Decode, opCode==0: func 1,3,4,5,6,7,8,9,10 SHALL map to select 0,1,2,3,4,5,6,7,8; func 11 (mul) to 13; func 12 (div) to 14.
REQ-019 Decode, opCode!=0: opCode 1,2,3,4 SHALL map to select 9,10,11,12.
REQ-020 Any other code SHALL be undefined and SHALL yield select all-ones.
REQ-021 FSM states SHALL be IDLE, EXEC, and VALID.
REQ-022 in_ready SHALL be 1 in IDLE, equal to out_ready in VALID, and 0 in EXEC.
REQ-023 Single-cycle op accepted at edge N: VALID with out_valid=1 from edge N+1.
REQ-024 Mul/div accepted at edge N: EXEC, busy=1, out_valid asserted from edge N+MUL_CYCLES or N+DIV_CYCLES.
REQ-025 EXEC SHALL use a 4-bit down-counter; requests are not accepted in EXEC.
REQ-026 In VALID with out_ready=0, alu_sel, illegal, and out_valid SHALL hold stable.
REQ-027 In VALID with out_ready=1 and a new request, the new request is accepted in the same cycle (back-to-back); otherwise the FSM goes to IDLE with out_valid=0.
REQ-028 busy SHALL be 1 exactly while in EXEC.

Reset
REQ-029 While rst=1, and asynchronously on its assertion: state=IDLE, out_valid=0, alu_sel=0, busy=0, illegal=0, err_cnt=0, counter=0.
REQ-030 Reset mid-EXEC or mid-VALID SHALL discard the pending op; no result is produced after release.
REQ-031 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after release.

Configuration
REQ-032 Macro ALU_OP_ILLEGAL_TRAP_EN defined: an undefined code SHALL produce a result with illegal=1, and err_cnt SHALL increment per such accept, saturating at 255.
REQ-033 Macro ALU_OP_ILLEGAL_TRAP_EN undefined: illegal and err_cnt SHALL be tied 0; undefined codes still yield all-ones with single-cycle latency.

Structure
REQ-034 Shared package alu_op_pkg SHALL hold the select constants, the opcode/func constants, and the FSM state enum.
REQ-035 Decode SHALL be one combinational sub-module, alu_op_decode (inputs opCode/func; outputs sel, multi-cycle flag, divide flag, undefined flag); the sequencer registers its outputs.

Verification
REQ-036 opCode=0, func=4, out_ready=1 -> alu_sel=2 with out_valid=1 one cycle after accept, for exactly one cycle.
REQ-037 opCode=0, func=12, defaults -> busy=1 for 8 cycles, then alu_sel=14 with out_valid=1; in_valid held during EXEC is not accepted.
REQ-038 opCode=3, out_ready held 0 for 5 cycles -> alu_sel=11 and out_valid stable for 5 cycles; on out_ready=1, a queued opCode=1 is accepted in the same cycle and alu_sel=9 next cycle.
REQ-039 With the macro defined, 300 requests of opCode=7 -> illegal=1 on each, alu_sel=15, err_cnt saturates at 255; without the macro, illegal=0 and err_cnt=0.
REQ-040 rst pulsed 2 cycles into a mul (MUL_CYCLES=3) -> out_valid, busy, and alu_sel are 0 immediately, and no result appears afterwards.
